uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with oversampled start-bit qualification, configurable frame format, error detection and a first-word-fall-through receive FIFO. It replaces the fixed 8N1 receive path behind the board `uart_rx` pin and feeds the matrix storage/calculation logic with buffered bytes, so the consumer no longer has to take each byte on the cycle it completes. Error flags and a busy indicator drive status LEDs.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. Divisor `DIV = (CLK_FREQ + BAUD/2) / BAUD`, which gives 868 at the defaults.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16: receive FIFO depth. Must be a power of 2, at least 2.

Ports:
- `clk`, input, 1: single system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `uart_rx`, input, 1: serial line. Asynchronous to `clk`; idles high.
- `rd_en`, input, 1: pops the FIFO head. Ignored when `rd_valid` = 0.
- `err_clr`, input, 1: single-cycle clear of all sticky error flags.
- `rd_data`, output, DATA_BITS: FIFO head. Valid whenever `rd_valid` = 1.
- `rd_valid`, output, 1: FIFO is not empty.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- `byte_done`, output, 1: one-cycle pulse when a good byte is written into the FIFO.
- `parity_err`, output, 1: sticky flag.
- `frame_err`, output, 1: sticky flag.
- `overrun`, output, 1: sticky flag.
- `uart_rx_work`, output, 1: high while the FSM is in any state other than IDLE.

## Operation
- `uart_rx` passes through a 2-FF synchroniser preset to 1; the result is `rxs`. A falling edge on `rxs` in IDLE starts a frame.
- A bit counter runs 0..DIV-1 for each bit. Each bit is sampled at counts DIV/2-1, DIV/2 and DIV/2+1. The bit value is the majority of the three samples, decided at count DIV/2+1.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE → START on a falling edge of `rxs`.
- START: if the majority is 1, the low pulse was a glitch; go back to IDLE and write nothing. Otherwise go to DATA.
- DATA: shift in DATA_BITS bits, LSB first. Then go to PAR if PARITY ≠ 0, otherwise to STOP.
- PAR: sample the parity bit and compare it with the XOR of the data bits under the selected odd/even rule.
- STOP: sample STOP_BITS stop bits in sequence. All must be 1.
- End-of-frame decision, made at the last stop bit's decision point:
  - Any stop bit is 0: discard the byte, set `frame_err`, go to BREAK.
  - Otherwise, parity mismatch: discard the byte, set `parity_err`, go to IDLE.
  - Otherwise, FIFO full with no simultaneous `rd_en`: discard the byte, set `overrun`, go to IDLE.
  - Otherwise: write the byte, pulse `byte_done`, go to IDLE.
- BREAK: wait until `rxs` = 1, then go to IDLE. This prevents a held-low line from producing phantom frames.
- The FSM returns to IDLE right after the last stop-bit decision, not at the end of the bit period. Back-to-back frames are therefore accepted.
- FIFO: circular buffer with read/write pointers one bit wider than the address, so full and empty are distinguished.
  - Write and read in the same cycle: allowed at any occupancy, including full. `fifo_count` is unchanged.
  - `rd_en` while empty: no pointer change.
- `err_clr` clears all three sticky flags. If a flag is set in the same cycle as `err_clr`, the set wins.
- Reset, asynchronous and at any point mid-frame, forces:
  - FSM to IDLE and all counters to 0;
  - FIFO pointers to 0;
  - `rd_valid` = 0, `fifo_count` = 0, `byte_done` = 0;
  - all three error flags = 0, `uart_rx_work` = 0;
  - `rd_data` = 0;
  - synchroniser to 1.
  
  The partial frame is lost.

## Timing
- Pin to `rxs`: 2 cycles.
- Start-edge detection to the first decision point: DIV/2+1 cycles. Each later bit decision follows the previous one by DIV cycles.
- The FIFO write occurs on the clock edge after the last stop-bit decision. `byte_done` is high for that one cycle.
- `rd_valid`, `rd_data` and `fifo_count` update on the same edge as the write.
- `rd_en` sampled high advances the head. The new `rd_data` appears on the following edge.
- `uart_rx_work` rises the cycle after start-edge detection. It falls the cycle after the return to IDLE.

## Test plan
All scenarios use defaults unless stated, with a bit time of 8680 ns.
- **8N1 sequence:** send 0x01, 0x02, 0x03 back to back. Expect `byte_done` ×3, `fifo_count` = 3, and pops returning 01, 02, 03 in order. All error flags stay 0.
- **Glitch rejection:** drive `uart_rx` low for 2000 ns, then high. Expect no write, `fifo_count` = 0, and `uart_rx_work` back to 0 within DIV cycles.
- **Framing error and recovery:** send 0x55 with a stop bit of 0 and hold the line low for 20 µs. Expect `frame_err` = 1, `fifo_count` = 0, FSM in BREAK. Release the line and send 0xA5; expect 0xA5 to be read.
- **Parity, even-parity instance (PARITY = 2):** send 0x03 with parity bit 1; expect `parity_err` = 1 and no write. Send 0x03 with parity bit 0; expect the byte accepted. Pulse `err_clr`; expect `parity_err` = 0.
- **Overrun, FIFO_DEPTH = 4:** send 0x10..0x14 without reading. Expect `fifo_count` = 4, `overrun` = 1, and pops returning 10, 11, 12, 13. Then fill to full and hold `rd_en` on the cycle a new byte lands; expect the byte accepted with `overrun` unchanged.
- **Reset mid-byte:** assert `rst` for 100 ns during data bit 3 of 0x3C. Expect all outputs at reset values. Then send 0x7E; expect exactly one byte, 0x7E, and no errors.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with majority-vote bit decisions,
// frame/parity/overrun detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          byte_done,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          uart_rx_work
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] S0   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] S1   = CW'(DIV / 2);
    localparam logic [CW-1:0] S2   = CW'(DIV / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

    state_t                 state_q, state_d;
    logic                   sync_q, rxs_q, rxs_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic [3:0]             bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic                   stop_bad_q, stop_bad_d;
    logic                   par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   byte_done_q, parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic                   maj, dec, full, wr, pe_set, fe_set, ov_set;

    assign maj  = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxs_q) | (smp_q[0] & rxs_q);
    assign dec  = cnt_q == S2;
    assign full = fifo_count == (AW + 1)'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        smp_d      = (cnt_q == S0 || cnt_q == S1) ? {smp_q[0], rxs_q} : smp_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        stop_bad_d = stop_bad_q;
        par_bad_d  = par_bad_q;
        data_d     = data_q;
        wr         = 1'b0;
        pe_set     = 1'b0;
        fe_set     = 1'b0;
        ov_set     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // the detection cycle itself counts as bit-time 0
                if (rxs_prev_q & ~rxs_q) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                end
            end
            START: if (dec) begin
                state_d    = maj ? IDLE : DATA;
                bit_d      = '0;
                stop_d     = 1'b0;
                stop_bad_d = 1'b0;
                par_bad_d  = 1'b0;
            end
            DATA: if (dec) begin
                data_d = {maj, data_q[DATA_BITS-1:1]};
                bit_d  = bit_q + 4'd1;
                if (bit_q == 4'(DATA_BITS - 1)) state_d = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (dec) begin
                par_bad_d = maj != ((PARITY == 1) ? ~^data_q : ^data_q);
                state_d   = STOP;
            end
            STOP: if (dec) begin
                stop_d = stop_q + 1'b1;
                if (stop_q == 1'(STOP_BITS - 1)) begin
                    if (stop_bad_q | ~maj) begin
                        fe_set  = 1'b1;
                        state_d = BREAK;
                    end else if (par_bad_q) begin
                        pe_set  = 1'b1;
                        state_d = IDLE;
                    end else if (full & ~rd_en) begin
                        ov_set  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wr      = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    stop_bad_d = stop_bad_q | ~maj;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + (AW + 1)'(wr);
        rd_ptr_d     = rd_ptr_q + (AW + 1)'(rd_en & rd_valid);
        parity_err_d = pe_set | (parity_err_q & ~err_clr);
        frame_err_d  = fe_set | (frame_err_q & ~err_clr);
        overrun_d    = ov_set | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            cnt_q        <= '0;
            smp_q        <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            stop_bad_q   <= 1'b0;
            par_bad_q    <= 1'b0;
            data_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            byte_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= uart_rx;
            rxs_q        <= sync_q;
            rxs_prev_q   <= rxs_q;
            cnt_q        <= cnt_d;
            smp_q        <= smp_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            stop_bad_q   <= stop_bad_d;
            par_bad_q    <= par_bad_d;
            data_q       <= data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_done_q  <= wr;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // a write into a full FIFO with a simultaneous pop reuses the head slot
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q[AW-1:0]] <= data_q;
    end

    assign fifo_count   = wr_ptr_q - rd_ptr_q;
    assign rd_valid     = fifo_count != '0;
    assign rd_data      = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign byte_done    = byte_done_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign uart_rx_work = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench driving three receiver instances (8N1,
// even parity, 4-deep FIFO) from one shared serial line at a 16-cycle bit time.
module tb_uart_rx_fifo;
    localparam int CF  = 1_600_000;
    localparam int BR  = 100_000;
    localparam int DIV = (CF + BR / 2) / BR;

    logic clk = 1'b0, rst, uart_rx, rd_en, err_clr;
    logic [7:0] rd_data0, rd_data1, rd_data2;
    logic [4:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic rd_valid0, rd_valid1, rd_valid2, byte_done0, byte_done1, byte_done2;
    logic pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, work0, work1, work2;
    int passed = 0, total = 0;
    int bd0 = 0, bd1 = 0, bd2 = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR)) u0 (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_count(cnt0), .byte_done(byte_done0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .uart_rx_work(work0));
    uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .PARITY(2)) u1 (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(cnt1), .byte_done(byte_done1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .uart_rx_work(work1));
    uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .fifo_count(cnt2), .byte_done(byte_done2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .uart_rx_work(work2));

    always @(posedge clk) begin
        bd0 <= bd0 + (byte_done0 ? 1 : 0);
        bd1 <= bd1 + (byte_done1 ? 1 : 0);
        bd2 <= bd2 + (byte_done2 ? 1 : 0);
    end

    function automatic logic [15:0] f8(input logic [7:0] b);
        return {6'b0, 1'b1, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            uart_rx = bits[i];
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic pop;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; uart_rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rd_valid0 !== 1'b0) $display("FAIL reset_rd_valid: got %0h expected 0", rd_valid0); else passed++;
        total++; if (cnt0 !== 5'd0) $display("FAIL reset_count: got %0d expected 0", cnt0); else passed++;
        total++; if (byte_done0 !== 1'b0) $display("FAIL reset_byte_done: got %0h expected 0", byte_done0); else passed++;
        total++; if ({pe0, fe0, ov0} !== 3'b000) $display("FAIL reset_errs: got %b expected 000", {pe0, fe0, ov0}); else passed++;
        total++; if (work0 !== 1'b0) $display("FAIL reset_work: got %0h expected 0", work0); else passed++;
        total++; if (rd_data0 !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data0); else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1;
        int s;
        do_reset();
        s = bd0;
        for (int b = 1; b <= 3; b++) send_bits(f8(8'(b)), 10);
        repeat (2) @(negedge clk);
        total++; if (bd0 - s !== 3) $display("FAIL 8n1_byte_done: got %0d expected 3", bd0 - s); else passed++;
        total++; if (cnt0 !== 5'd3) $display("FAIL 8n1_count: got %0d expected 3", cnt0); else passed++;
        total++; if ({pe0, fe0, ov0} !== 3'b000) $display("FAIL 8n1_errs: got %b expected 000", {pe0, fe0, ov0}); else passed++;
        for (int b = 1; b <= 3; b++) begin
            total++; if (rd_data0 !== 8'(b)) $display("FAIL 8n1_pop%0d: got %h expected %h", b, rd_data0, 8'(b)); else passed++;
            pop();
        end
        total++; if (rd_valid0 !== 1'b0) $display("FAIL 8n1_empty: got %0h expected 0", rd_valid0); else passed++;
    endtask

    task automatic test_glitch;
        int s;
        do_reset();
        s = bd0;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        total++; if (work0 !== 1'b1) $display("FAIL glitch_start: got %0h expected 1", work0); else passed++;
        repeat (DIV) @(negedge clk);
        total++; if (work0 !== 1'b0) $display("FAIL glitch_work: got %0h expected 0", work0); else passed++;
        total++; if (cnt0 !== 5'd0) $display("FAIL glitch_count: got %0d expected 0", cnt0); else passed++;
        total++; if (bd0 - s !== 0) $display("FAIL glitch_byte_done: got %0d expected 0", bd0 - s); else passed++;
    endtask

    task automatic test_frame_err;
        do_reset();
        send_bits({6'b0, 1'b0, 8'h55, 1'b0}, 10);
        repeat (2 * DIV) @(negedge clk);
        total++; if (fe0 !== 1'b1) $display("FAIL ferr_flag: got %0h expected 1", fe0); else passed++;
        total++; if (cnt0 !== 5'd0) $display("FAIL ferr_count: got %0d expected 0", cnt0); else passed++;
        total++; if (work0 !== 1'b1) $display("FAIL ferr_break: got %0h expected 1", work0); else passed++;
        uart_rx = 1'b1;
        repeat (DIV) @(negedge clk);
        total++; if (work0 !== 1'b0) $display("FAIL ferr_release: got %0h expected 0", work0); else passed++;
        send_bits(f8(8'hA5), 10);
        repeat (2) @(negedge clk);
        total++; if (cnt0 !== 5'd1) $display("FAIL ferr_recover_count: got %0d expected 1", cnt0); else passed++;
        total++; if (rd_data0 !== 8'hA5) $display("FAIL ferr_recover_data: got %h expected a5", rd_data0); else passed++;
        total++; if (fe0 !== 1'b1) $display("FAIL ferr_sticky: got %0h expected 1", fe0); else passed++;
    endtask

    task automatic test_reset_mid;
        int s;
        total++; if (cnt0 !== 5'd1) $display("FAIL rmid_pre_count: got %0d expected 1", cnt0); else passed++;
        send_bits(f8(8'h3C), 4);
        uart_rx = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        total++; if (work0 !== 1'b1) $display("FAIL rmid_busy: got %0h expected 1", work0); else passed++;
        rst = 1'b1;
        #1;
        total++; if (work0 !== 1'b0) $display("FAIL rmid_work: got %0h expected 0", work0); else passed++;
        total++; if (rd_valid0 !== 1'b0) $display("FAIL rmid_rd_valid: got %0h expected 0", rd_valid0); else passed++;
        total++; if (cnt0 !== 5'd0) $display("FAIL rmid_count: got %0d expected 0", cnt0); else passed++;
        total++; if (rd_data0 !== 8'h00) $display("FAIL rmid_rd_data: got %h expected 00", rd_data0); else passed++;
        total++; if (fe0 !== 1'b0) $display("FAIL rmid_ferr: got %0h expected 0", fe0); else passed++;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        s = bd0;
        send_bits(f8(8'h7E), 10);
        repeat (2) @(negedge clk);
        total++; if (bd0 - s !== 1) $display("FAIL rmid_byte_done: got %0d expected 1", bd0 - s); else passed++;
        total++; if (cnt0 !== 5'd1) $display("FAIL rmid_count_after: got %0d expected 1", cnt0); else passed++;
        total++; if (rd_data0 !== 8'h7E) $display("FAIL rmid_data: got %h expected 7e", rd_data0); else passed++;
        total++; if ({pe0, fe0, ov0} !== 3'b000) $display("FAIL rmid_errs: got %b expected 000", {pe0, fe0, ov0}); else passed++;
    endtask

    task automatic test_parity;
        int s;
        do_reset();
        s = bd1;
        send_bits({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        repeat (2) @(negedge clk);
        total++; if (pe1 !== 1'b1) $display("FAIL par_bad_flag: got %0h expected 1", pe1); else passed++;
        total++; if (cnt1 !== 5'd0) $display("FAIL par_bad_count: got %0d expected 0", cnt1); else passed++;
        send_bits({5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        repeat (2) @(negedge clk);
        total++; if (cnt1 !== 5'd1) $display("FAIL par_good_count: got %0d expected 1", cnt1); else passed++;
        total++; if (rd_data1 !== 8'h03) $display("FAIL par_good_data: got %h expected 03", rd_data1); else passed++;
        total++; if (bd1 - s !== 1) $display("FAIL par_byte_done: got %0d expected 1", bd1 - s); else passed++;
        total++; if (pe1 !== 1'b1) $display("FAIL par_sticky: got %0h expected 1", pe1); else passed++;
        pulse_clr();
        total++; if (pe1 !== 1'b0) $display("FAIL par_clear: got %0h expected 0", pe1); else passed++;
    endtask

    task automatic test_overrun;
        int s;
        do_reset();
        for (int b = 8'h10; b <= 8'h14; b++) send_bits(f8(8'(b)), 10);
        repeat (2) @(negedge clk);
        total++; if (cnt2 !== 3'd4) $display("FAIL ovr_count: got %0d expected 4", cnt2); else passed++;
        total++; if (ov2 !== 1'b1) $display("FAIL ovr_flag: got %0h expected 1", ov2); else passed++;
        for (int b = 8'h10; b <= 8'h13; b++) begin
            total++; if (rd_data2 !== 8'(b)) $display("FAIL ovr_pop: got %h expected %h", rd_data2, 8'(b)); else passed++;
            pop();
        end
        total++; if (rd_valid2 !== 1'b0) $display("FAIL ovr_empty: got %0h expected 0", rd_valid2); else passed++;
        pulse_clr();
        s = bd2;
        for (int b = 8'h20; b <= 8'h23; b++) send_bits(f8(8'(b)), 10);
        total++; if (cnt2 !== 3'd4) $display("FAIL ovr_full: got %0d expected 4", cnt2); else passed++;
        fork
            send_bits(f8(8'h24), 10);
            begin
                repeat (3 + DIV / 2 + 9 * DIV) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        total++; if (cnt2 !== 3'd4) $display("FAIL ovr_rw_count: got %0d expected 4", cnt2); else passed++;
        total++; if (ov2 !== 1'b0) $display("FAIL ovr_rw_flag: got %0h expected 0", ov2); else passed++;
        total++; if (bd2 - s !== 5) $display("FAIL ovr_rw_byte_done: got %0d expected 5", bd2 - s); else passed++;
        for (int b = 8'h21; b <= 8'h24; b++) begin
            total++; if (rd_data2 !== 8'(b)) $display("FAIL ovr_rw_pop: got %h expected %h", rd_data2, 8'(b)); else passed++;
            pop();
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_parity();
        test_overrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
